ir_frame_decoder: RTL and testbench

Parametrised pulse-distance IR frame receiver, NEC-style. Sits between the demodulated IR receiver pin and game control logic. Generalises the fixed 3-bit remote decoder:
- configurable payload width and all timing thresholds in prescaled ticks;
- leader validation and repeat-code detection;
- optional complement check;
- timeout and error reporting.

---
 rtl/ir_frame_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_ir_frame_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_frame_decoder.sv
// Pulse-distance (NEC-style) IR frame receiver.
// Measures alternating mark/space phases in prescaled ticks. It validates the
// leader, recognises repeat frames and assembles an LSB-first payload, with an
// optional complement check. Rejected frames raise a one-clk err pulse with a cause.
module ir_frame_decoder #(
  parameter int DATA_BITS   = 8,
  parameter int CLK_DIV     = 50,
  parameter int LEAD_LO_MIN = 8000,
  parameter int LEAD_HI_MIN = 4000,
  parameter int RPT_HI_MIN  = 2000,
  parameter int BIT_THRESH  = 1000,
  parameter int TIMEOUT     = 10000,
  parameter int CHECK_INV   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 irda,
  output logic [DATA_BITS-1:0] code,
  output logic                 code_valid,
  output logic                 repeat_pulse,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int HALF  = DATA_BITS / 2;

  typedef enum logic [2:0] {
    IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, CHECK
  } state_t;

  state_t state_reg, state_next;

  logic sync1_reg, sync2_reg, sync3_reg;
  logic fall, rise;
  logic [PRE_W-1:0] pre_reg;
  logic tick;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0] cnt_ext;
  logic timed_out;
  logic bit_val;

  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next, shift_in;
  logic [DATA_BITS-1:0] code_reg, code_next;
  logic                 have_reg, have_next;
  logic                 cv_reg, cv_next;
  logic                 rp_reg, rp_next;
  logic                 err_reg, err_next;
  logic [1:0]           ec_reg, ec_next;
  logic                 inv_bad;

  // Two-FF synchroniser plus one delay stage used only for edge detection.
  // Resets to the idle-high level so reset release never looks like a mark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      sync3_reg <= 1'b1;
    end else begin
      sync1_reg <= irda;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign fall = sync3_reg & ~sync2_reg;
  assign rise = ~sync3_reg & sync2_reg;

  // Free-running prescaler producing one tick every CLK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pre_reg <= '0;
    else if (tick) pre_reg <= '0;
    else           pre_reg <= pre_reg + PRE_W'(1);
  end

  assign tick = (pre_reg == PRE_W'(CLK_DIV - 1));

  // Phase length counter: cleared by any edge, counts ticks, sticks at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else if (fall || rise)
      cnt_reg <= '0;
    else if (tick && !timed_out)
      cnt_reg <= cnt_reg + CNT_W'(1);
  end

  assign cnt_ext   = {{(32 - CNT_W){1'b0}}, cnt_reg};
  assign timed_out = (cnt_reg == CNT_W'(TIMEOUT));
  assign bit_val   = (cnt_ext >= 32'(BIT_THRESH));

  // New bit enters at the MSB so the first received bit ends up in bit 0.
  generate
    if (DATA_BITS > 1) begin : g_shift
      assign shift_in = {bit_val, shift_reg[DATA_BITS-1:1]};
    end else begin : g_shift1
      assign shift_in = bit_val;
    end
  endgenerate

  // Complement check: any bit of the upper half equal to its lower-half partner fails.
  generate
    if (CHECK_INV != 0 && HALF > 0) begin : g_inv
      logic [HALF-1:0] same;
      for (genvar gi = 0; gi < HALF; gi++) begin : g_pair
        assign same[gi] = (shift_reg[gi + HALF] == shift_reg[gi]);
      end
      assign inv_bad = |same;
    end else begin : g_noinv
      assign inv_bad = 1'b0;
    end
  endgenerate

  // Frame state machine: next state, payload assembly and registered pulse requests.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    code_next  = code_reg;
    have_next  = have_reg;
    cv_next    = 1'b0;
    rp_next    = 1'b0;
    err_next   = 1'b0;
    ec_next    = ec_reg;
    case (state_reg)
      IDLE: begin
        if (fall) state_next = LEAD_LO;
      end
      LEAD_LO: begin
        if (timed_out) begin
          err_next   = 1'b1;
          ec_next    = 2'd2;
          state_next = IDLE;
        end else if (rise) begin
          if (cnt_ext >= 32'(LEAD_LO_MIN)) begin
            state_next = LEAD_HI;
          end else begin
            err_next   = 1'b1;
            ec_next    = 2'd1;
            state_next = IDLE;
          end
        end
      end
      LEAD_HI: begin
        if (timed_out) begin
          err_next   = 1'b1;
          ec_next    = 2'd2;
          state_next = IDLE;
        end else if (fall) begin
          if (cnt_ext >= 32'(LEAD_HI_MIN)) begin
            idx_next   = '0;
            shift_next = '0;
            state_next = BIT_LO;
          end else if (cnt_ext >= 32'(RPT_HI_MIN)) begin
            // A repeat means nothing until at least one code has been accepted.
            rp_next    = have_reg;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            ec_next    = 2'd1;
            state_next = IDLE;
          end
        end
      end
      BIT_LO: begin
        if (timed_out) begin
          err_next   = 1'b1;
          ec_next    = 2'd2;
          state_next = IDLE;
        end else if (rise) begin
          state_next = BIT_HI;
        end
      end
      BIT_HI: begin
        if (timed_out) begin
          err_next   = 1'b1;
          ec_next    = 2'd2;
          state_next = IDLE;
        end else if (fall) begin
          shift_next = shift_in;
          if (idx_reg == IDX_W'(DATA_BITS - 1)) begin
            state_next = CHECK;
          end else begin
            idx_next   = idx_reg + IDX_W'(1);
            state_next = BIT_LO;
          end
        end
      end
      CHECK: begin
        if (inv_bad) begin
          err_next = 1'b1;
          ec_next  = 2'd3;
        end else begin
          code_next = shift_reg;
          cv_next   = 1'b1;
          have_next = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, payload and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      shift_reg <= '0;
      code_reg  <= '0;
      have_reg  <= 1'b0;
      cv_reg    <= 1'b0;
      rp_reg    <= 1'b0;
      err_reg   <= 1'b0;
      ec_reg    <= 2'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      code_reg  <= code_next;
      have_reg  <= have_next;
      cv_reg    <= cv_next;
      rp_reg    <= rp_next;
      err_reg   <= err_next;
      ec_reg    <= ec_next;
    end
  end

  assign code         = code_reg;
  assign code_valid   = cv_reg;
  assign repeat_pulse = rp_reg;
  assign err          = err_reg;
  assign err_code     = ec_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_ir_frame_decoder.sv
// Bench for ir_frame_decoder: two instances (complement check off and on) share
// one IR line. Directed table rows, a reset-mid-frame sequence, then random
// frames judged by a frame-level reference model.
module tb_ir_frame_decoder;
  localparam int TO = 20, LL = 8, LH = 4, RPT = 2, BT = 3;
  localparam int K_NONE = 0, K_VALID = 1, K_RPT = 2, K_ERR = 3;
  localparam int GAP = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irda = 1'b1;
  logic [7:0] code0, code1;
  logic cv0, cv1, rp0, rp1, er0, er1, busy0, busy1;
  logic [1:0] ec0, ec1;

  ir_frame_decoder #(.DATA_BITS(8), .CLK_DIV(1), .LEAD_LO_MIN(LL), .LEAD_HI_MIN(LH),
    .RPT_HI_MIN(RPT), .BIT_THRESH(BT), .TIMEOUT(TO), .CHECK_INV(0)) dut0 (
    .clk(clk), .rst(rst), .irda(irda), .code(code0), .code_valid(cv0),
    .repeat_pulse(rp0), .err(er0), .err_code(ec0), .busy(busy0));

  ir_frame_decoder #(.DATA_BITS(8), .CLK_DIV(1), .LEAD_LO_MIN(LL), .LEAD_HI_MIN(LH),
    .RPT_HI_MIN(RPT), .BIT_THRESH(BT), .TIMEOUT(TO), .CHECK_INV(1)) dut1 (
    .clk(clk), .rst(rst), .irda(irda), .code(code1), .code_valid(cv1),
    .repeat_pulse(rp1), .err(er1), .err_code(ec1), .busy(busy1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, txn = 0;
  int nv[2], nr[2], ne[2], vcyc[2], bad[2], exp_ec[2];
  logic [2:0] prev_p[2];
  int last_fall = 0;
  int segs[40];
  int nseg = 0;

  typedef struct {
    int lead_lo; int lead_hi; int nbits; logic [7:0] payload; int tail_hi;
    int k0; logic [7:0] c0; int e0;
    int k1; logic [7:0] c1; int e1;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Pulse monitor: counts pulses and flags overlapping or stretched pulses.
  task automatic mon(input int d, input logic v, input logic r, input logic e);
    logic [2:0] p;
    p = {v, r, e};
    if (v) begin nv[d]++; vcyc[d] = cyc; end
    if (r) nr[d]++;
    if (e) ne[d]++;
    if ($countones(p) > 1 || (p & prev_p[d]) != 3'b000) bad[d]++;
    prev_p[d] = p;
  endtask

  always @(negedge clk) begin
    mon(0, cv0, rp0, er0);
    mon(1, cv1, rp1, er1);
  end

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      nv[d] = 0; nr[d] = 0; ne[d] = 0; bad[d] = 0; vcyc[d] = 0;
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    irda = lvl;
    if (!lvl) last_fall = cyc;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    segs[nseg] = v;
    nseg++;
  endtask

  // Frame as alternating low/high phase lengths; tail_hi>0 replaces the last
  // bit's space and drops the stop mark (line then stays high).
  task automatic build(input int lo, input int hi, input int nb, input logic [7:0] pl, input int tail);
    nseg = 0;
    push(lo);
    if (hi > 0) begin
      push(hi);
      for (int b = 0; b < nb; b++) begin
        push(1);
        if (b == nb - 1 && tail > 0) push(tail);
        else push(pl[b] ? 4 : 1);
      end
      if (tail == 0) push(1);
    end
  endtask

  // Counter value seen at the end of phase i: it clears in the phase's first
  // cycle, so it reads one less than the phase length. A high phase with
  // nothing after it merges with the idle line and never ends.
  function automatic int meas(input int s[40], input int n, input int i);
    if (i >= n || ((i % 2) == 1 && i == n - 1)) return 1000;
    return s[i] - 1;
  endfunction

  task automatic ref_model(input int s[40], input int n, input bit inv, input bit have,
                           output int kind, output int ec, output logic [7:0] val, output int used);
    int m;
    logic [7:0] v;
    bit stop;
    kind = K_NONE; ec = 0; val = '0; used = 0; v = '0; stop = 0;
    m = meas(s, n, 0); used = 1;
    if (m >= TO) begin kind = K_ERR; ec = 2; stop = 1; end
    else if (m < LL) begin kind = K_ERR; ec = 1; stop = 1; end
    if (!stop) begin
      m = meas(s, n, 1); used = 2;
      if (m >= TO) begin kind = K_ERR; ec = 2; stop = 1; end
      else if (m < RPT) begin kind = K_ERR; ec = 1; stop = 1; end
      else if (m < LH) begin kind = have ? K_RPT : K_NONE; stop = 1; end
    end
    for (int i = 2; i < 18 && !stop; i++) begin
      m = meas(s, n, i); used = i + 1;
      if (m >= TO) begin kind = K_ERR; ec = 2; stop = 1; end
      else if (i % 2 == 1) v[(i - 2) / 2] = (m >= BT);
    end
    if (!stop) begin
      if (inv && v[7:4] != ~v[3:0]) begin kind = K_ERR; ec = 3; end
      else begin kind = K_VALID; val = v; end
    end
  endtask

  task automatic check_dut(input int d, input string tag, input int kind, input logic [7:0] c, input int e);
    logic [7:0] ac;
    logic [1:0] aec;
    logic ab;
    int exp_ev;
    if (d == 0) begin ac = code0; aec = ec0; ab = busy0; end
    else begin ac = code1; aec = ec1; ab = busy1; end
    if (kind == K_ERR) exp_ec[d] = e;
    exp_ev = (kind == K_VALID) ? 100 : (kind == K_RPT) ? 10 : (kind == K_ERR) ? 1 : 0;
    chk($sformatf("%s.dut%0d.events(v*100+r*10+e)", tag, d), nv[d] * 100 + nr[d] * 10 + ne[d], exp_ev);
    chk($sformatf("%s.dut%0d.code", tag, d), int'(ac), int'(c));
    chk($sformatf("%s.dut%0d.err_code", tag, d), int'(aec), exp_ec[d]);
    chk($sformatf("%s.dut%0d.busy", tag, d), int'(ab), 0);
    chk($sformatf("%s.dut%0d.pulse_shape", tag, d), bad[d], 0);
    if (kind == K_VALID)
      chk($sformatf("%s.dut%0d.latency", tag, d), vcyc[d] - last_fall, 4);
  endtask

  task automatic run_frame(input string tag, input int k0, input logic [7:0] c0, input int e0,
                           input int k1, input logic [7:0] c1, input int e1);
    clear_mon();
    for (int i = 0; i < nseg; i++) drive((i % 2) == 1, segs[i]);
    drive(1'b1, GAP);
    txn++;
    $display("txn %0d %s phases=%0d dut0 kind=%0d code=%02h | dut1 kind=%0d code=%02h",
             txn, tag, nseg, k0, c0, k1, c1);
    check_dut(0, tag, k0, c0, e0);
    check_dut(1, tag, k1, c1, e1);
  endtask

  initial begin
    bit have[2];
    logic [7:0] expc[2];
    int k[2], e[2], used, used_dummy;
    logic [7:0] val[2];
    logic [7:0] pl;
    logic [3:0] lo_nib;
    int ek, ee;

    tbl[0] = '{10, 3, 0, 8'h00, 0,  K_NONE,  8'h00, 0, K_NONE,  8'h00, 0};
    tbl[1] = '{10, 5, 8, 8'h05, 0,  K_VALID, 8'h05, 0, K_ERR,   8'h00, 3};
    tbl[2] = '{10, 3, 0, 8'h00, 0,  K_RPT,   8'h05, 0, K_NONE,  8'h00, 0};
    tbl[3] = '{5,  0, 0, 8'h00, 0,  K_ERR,   8'h05, 1, K_ERR,   8'h00, 1};
    tbl[4] = '{10, 5, 3, 8'h05, 30, K_ERR,   8'h05, 2, K_ERR,   8'h00, 2};
    tbl[5] = '{10, 5, 8, 8'h05, 0,  K_VALID, 8'h05, 0, K_ERR,   8'h00, 3};
    tbl[6] = '{10, 5, 8, 8'hA5, 0,  K_VALID, 8'hA5, 0, K_VALID, 8'hA5, 0};
    tbl[7] = '{10, 5, 8, 8'hB5, 0,  K_VALID, 8'hB5, 0, K_ERR,   8'hA5, 3};
    tbl[8] = '{10, 3, 0, 8'h00, 0,  K_RPT,   8'hB5, 0, K_RPT,   8'hA5, 0};

    for (int d = 0; d < 2; d++) begin exp_ec[d] = 0; prev_p[d] = 3'b000; end
    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 5);
    chk("reset.dut0.outputs", int'({code0, cv0, rp0, er0, ec0, busy0}), 0);
    chk("reset.dut1.outputs", int'({code1, cv1, rp1, er1, ec1, busy1}), 0);

    for (int r = 0; r < 9; r++) begin
      build(tbl[r].lead_lo, tbl[r].lead_hi, tbl[r].nbits, tbl[r].payload, tbl[r].tail_hi);
      run_frame($sformatf("table%0d", r), tbl[r].k0, tbl[r].c0, tbl[r].e0,
                tbl[r].k1, tbl[r].c1, tbl[r].e1);
    end

    // Reset during the space of the fourth bit, then a clean frame.
    build(10, 5, 8, 8'h3C, 0);
    clear_mon();
    for (int i = 0; i < 9; i++) drive((i % 2) == 1, segs[i]);
    drive(1'b1, 2);
    chk("midreset.busy_before", int'(busy0), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset.dut0.outputs", int'({code0, cv0, rp0, er0, ec0, busy0}), 0);
    chk("midreset.dut1.outputs", int'({code1, cv1, rp1, er1, ec1, busy1}), 0);
    rst = 1'b0;
    exp_ec[0] = 0; exp_ec[1] = 0;
    drive(1'b1, GAP);
    chk("midreset.no_pulses", nv[0] + nr[0] + ne[0] + nv[1] + nr[1] + ne[1], 0);
    build(10, 5, 8, 8'h3C, 0);
    run_frame("after_reset", K_VALID, 8'h3C, 0, K_VALID, 8'h3C, 0);

    have[0] = 1; have[1] = 1;
    expc[0] = 8'h3C; expc[1] = 8'h3C;

    for (int t = 0; t < 60; t++) begin
      lo_nib = 4'($urandom);
      pl = ($urandom_range(0, 1) == 1) ? {~lo_nib, lo_nib} : 8'($urandom);
      nseg = 0;
      push($urandom_range(4, 24));
      push($urandom_range(1, 23));
      for (int b = 0; b < 8; b++) begin
        push(($urandom_range(0, 29) == 0) ? 22 : $urandom_range(1, 3));
        if ($urandom_range(0, 39) == 0) push(22);
        else push(pl[b] ? $urandom_range(4, 6) : $urandom_range(1, 3));
      end
      push(1);
      // Keep only the phases the receiver acts on, so leftover edges do not
      // start a second frame; a frame ended by a falling edge gets a stop mark.
      ref_model(segs, nseg, 1'b0, have[0], ek, ee, pl, used);
      nseg = used;
      if (used % 2 == 0 && !(ek == K_ERR && ee == 2)) push(1);
      for (int d = 0; d < 2; d++) begin
        ref_model(segs, nseg, d == 1, have[d], k[d], e[d], val[d], used_dummy);
        if (k[d] == K_VALID) begin have[d] = 1; expc[d] = val[d]; end
      end
      run_frame($sformatf("rand%0d", t), k[0], expc[0], e[0], k[1], expc[1], e[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
